counter_timer_pwm: RTL and testbench

//  Parametrised counter/timer: WIDTH-bit up/down counter with 16-bit clock prescaler,

---
 rtl/counter_timer_pwm.sv | 227 ++++++++++++++++++++++
 tb/tb_counter_timer_pwm.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_pwm.sv
// WIDTH-bit up/down counter/timer with prescaler, compare-driven PWM, synchronised
// input capture and a W1C status register that feeds one level interrupt.
module counter_timer_pwm #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clkin,
   input  logic                 resetn,
   input  logic [3:0]           reg_cfg_we,
   input  logic [31:0]          reg_cfg_di,
   output logic [31:0]          reg_cfg_do,
   input  logic [WIDTH/8-1:0]   reg_val_we,
   input  logic [WIDTH-1:0]     reg_val_di,
   output logic [WIDTH-1:0]     reg_val_do,
   input  logic [WIDTH/8-1:0]   reg_cmp_we,
   input  logic [WIDTH-1:0]     reg_cmp_di,
   output logic [WIDTH-1:0]     reg_cmp_do,
   input  logic [WIDTH/8-1:0]   reg_dat_we,
   input  logic [WIDTH-1:0]     reg_dat_di,
   output logic [WIDTH-1:0]     reg_dat_do,
   output logic [WIDTH-1:0]     reg_cap_do,
   input  logic                 reg_sts_we,
   input  logic [31:0]          reg_sts_di,
   output logic [31:0]          reg_sts_do,
   input  logic                 cap_in,
   output logic                 pwm_out,
   output logic                 stop_out,
   output logic                 irq_out
);

   localparam int NB = WIDTH / 8;
   localparam logic [31:0]      CFG_MASK = 32'hFFFF_07FF;
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old_val,
                                                 input logic [WIDTH-1:0] new_val,
                                                 input logic [NB-1:0]    be);
      logic [WIDTH-1:0] res;
      res = old_val;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) begin
            res[i*8 +: 8] = new_val[i*8 +: 8];
         end else begin
            res[i*8 +: 8] = old_val[i*8 +: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [31:0] merge_32(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[i*8 +: 8] = new_val[i*8 +: 8];
         end else begin
            res[i*8 +: 8] = old_val[i*8 +: 8];
         end
      end
      return res;
   endfunction

   logic [31:0]            cfg;
   logic [WIDTH-1:0]       value_reset;
   logic [WIDTH-1:0]       value_cmp;
   logic [WIDTH-1:0]       value_cur;
   logic [WIDTH-1:0]       value_cap;
   logic [3:0]             sts;
   logic                   last_en;
   logic [15:0]            pre_cnt;
   logic                   stop;
   logic                   pwm;
   logic                   irq;
   logic [SYNC_STAGES-1:0] cap_sync;
   logic                   cap_last;

   logic [31:0]            cfg_next;
   logic [WIDTH-1:0]       value_cur_next;
   logic [15:0]            pre_cnt_next;
   logic                   stop_next;
   logic [3:0]             sts_next;
   logic [3:0]             sts_set;
   logic [3:0]             sts_clr;
   logic                   pwm_next;
   logic                   irq_next;

   logic cfg_en, cfg_oneshot, cfg_up, cfg_to_irq, cfg_cmp_irq;
   logic cfg_pwm_en, cfg_pwm_pol, cfg_cap_en, cfg_cap_irq;
   logic [1:0]  cfg_cap_edge;
   logic [15:0] cfg_prescale;
   logic en_rise, tick, at_end, timeout_ev, oneshot_stop, cmp_ev;
   logic cap_rise, cap_fall, cap_ev;
   logic unused_bits;

   assign cfg_en       = cfg[0];
   assign cfg_oneshot  = cfg[1];
   assign cfg_up       = cfg[2];
   assign cfg_to_irq   = cfg[3];
   assign cfg_cmp_irq  = cfg[4];
   assign cfg_pwm_en   = cfg[5];
   assign cfg_pwm_pol  = cfg[6];
   assign cfg_cap_en   = cfg[7];
   assign cfg_cap_edge = cfg[9:8];
   assign cfg_cap_irq  = cfg[10];
   assign cfg_prescale = cfg[31:16];
   assign unused_bits  = ^{reg_sts_di[31:4], cfg[15:11]};

   // Event decode: the enable-rise cycle resets the prescaler and never counts
   always_comb begin
      en_rise      = cfg_en & ~last_en;
      tick         = cfg_en & ~en_rise & (pre_cnt == cfg_prescale);
      at_end       = cfg_up ? (value_cur == value_reset) : (value_cur == ZERO_W);
      timeout_ev   = tick & at_end;
      oneshot_stop = timeout_ev & cfg_oneshot;
      cmp_ev       = tick & (value_cur == value_cmp);
      cap_rise     = cap_sync[SYNC_STAGES-1] & ~cap_last;
      cap_fall     = ~cap_sync[SYNC_STAGES-1] & cap_last;
      cap_ev       = cfg_cap_en & ((cfg_cap_edge[0] & cap_rise) | (cfg_cap_edge[1] & cap_fall));
   end

   // Next-state for configuration, prescaler, counter, stop flag and status
   always_comb begin
      cfg_next = cfg;
      if (oneshot_stop) begin
         cfg_next[0] = 1'b0;
      end else begin
         cfg_next[0] = cfg[0];
      end
      if (reg_cfg_we != 4'd0) begin
         cfg_next = merge_32(cfg_next, reg_cfg_di, reg_cfg_we) & CFG_MASK;
      end else begin
         cfg_next = cfg_next & CFG_MASK;
      end

      pre_cnt_next = pre_cnt;
      if (!cfg_en || en_rise || (pre_cnt == cfg_prescale)) begin
         pre_cnt_next = 16'd0;
      end else begin
         pre_cnt_next = pre_cnt + 16'd1;
      end

      value_cur_next = value_cur;
      if (reg_dat_we != {NB{1'b0}}) begin
         value_cur_next = merge_w(value_cur, reg_dat_di, reg_dat_we);
      end else if (en_rise) begin
         value_cur_next = cfg_up ? ZERO_W : value_reset;
      end else if (tick) begin
         if (at_end) begin
            if (cfg_oneshot) begin
               value_cur_next = value_cur;
            end else begin
               value_cur_next = cfg_up ? ZERO_W : value_reset;
            end
         end else begin
            value_cur_next = cfg_up ? (value_cur + ONE_W) : (value_cur - ONE_W);
         end
      end else begin
         value_cur_next = value_cur;
      end

      stop_next = stop;
      if (en_rise) begin
         stop_next = 1'b0;
      end else if (oneshot_stop) begin
         stop_next = 1'b1;
      end else begin
         stop_next = stop;
      end

      // A set in the same cycle as a W1C clear keeps the flag
      sts_set  = {cap_ev & sts[2], cap_ev, cmp_ev, timeout_ev};
      sts_clr  = reg_sts_we ? reg_sts_di[3:0] : 4'd0;
      sts_next = (sts & ~sts_clr) | sts_set;

      pwm_next = cfg_pwm_en ? ((value_cur < value_cmp) ^ cfg_pwm_pol) : cfg_pwm_pol;
      irq_next = (sts[0] & cfg_to_irq) | (sts[1] & cfg_cmp_irq) | (sts[2] & cfg_cap_irq);
   end

   // State registers, capture synchroniser and registered outputs
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         cfg         <= 32'd0;
         value_reset <= ZERO_W;
         value_cmp   <= ZERO_W;
         value_cur   <= ZERO_W;
         value_cap   <= ZERO_W;
         sts         <= 4'd0;
         last_en     <= 1'b0;
         pre_cnt     <= 16'd0;
         stop        <= 1'b0;
         pwm         <= 1'b0;
         irq         <= 1'b0;
         cap_sync    <= {SYNC_STAGES{1'b0}};
         cap_last    <= 1'b0;
      end else begin
         cfg         <= cfg_next;
         value_reset <= merge_w(value_reset, reg_val_di, reg_val_we);
         value_cmp   <= merge_w(value_cmp, reg_cmp_di, reg_cmp_we);
         value_cur   <= value_cur_next;
         if (cap_ev) begin
            value_cap <= value_cur;
         end
         sts         <= sts_next;
         last_en     <= cfg_en;
         pre_cnt     <= pre_cnt_next;
         stop        <= stop_next;
         pwm         <= pwm_next;
         irq         <= irq_next;
         cap_sync    <= {cap_sync[SYNC_STAGES-2:0], cap_in};
         cap_last    <= cap_sync[SYNC_STAGES-1];
      end
   end

   assign reg_cfg_do = cfg;
   assign reg_val_do = value_reset;
   assign reg_cmp_do = value_cmp;
   assign reg_dat_do = value_cur;
   assign reg_cap_do = value_cap;
   assign reg_sts_do = {28'd0, sts};
   assign pwm_out    = pwm;
   assign stop_out   = stop;
   assign irq_out    = irq;

endmodule

// File: tb/tb_counter_timer_pwm.sv
// Directed self-checking bench for counter_timer_pwm: a 32-bit instance for most
// scenarios and a 16-bit instance for wrap-around and asynchronous reset.
module tb_counter_timer_pwm;

   logic        clkin = 1'b0;
   logic        resetn;
   logic [3:0]  reg_cfg_we;
   logic [31:0] reg_cfg_di;
   logic [31:0] reg_cfg_do;
   logic [3:0]  reg_val_we;
   logic [31:0] reg_val_di;
   logic [31:0] reg_val_do;
   logic [3:0]  reg_cmp_we;
   logic [31:0] reg_cmp_di;
   logic [31:0] reg_cmp_do;
   logic [3:0]  reg_dat_we;
   logic [31:0] reg_dat_di;
   logic [31:0] reg_dat_do;
   logic [31:0] reg_cap_do;
   logic        reg_sts_we;
   logic [31:0] reg_sts_di;
   logic [31:0] reg_sts_do;
   logic        cap_in;
   logic        pwm_out;
   logic        stop_out;
   logic        irq_out;

   logic [3:0]  s_cfg_we;
   logic [31:0] s_cfg_di;
   logic [31:0] s_cfg_do;
   logic [1:0]  s_val_we;
   logic [15:0] s_val_di;
   logic [15:0] s_val_do;
   logic [1:0]  s_cmp_we;
   logic [15:0] s_cmp_di;
   logic [15:0] s_cmp_do;
   logic [1:0]  s_dat_we;
   logic [15:0] s_dat_di;
   logic [15:0] s_dat_do;
   logic [15:0] s_cap_do;
   logic        s_sts_we;
   logic [31:0] s_sts_di;
   logic [31:0] s_sts_do;
   logic        s_cap_in;
   logic        s_pwm_out;
   logic        s_stop_out;
   logic        s_irq_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   counter_timer_pwm #(.WIDTH(32), .SYNC_STAGES(2)) dut (
      .clkin(clkin), .resetn(resetn),
      .reg_cfg_we(reg_cfg_we), .reg_cfg_di(reg_cfg_di), .reg_cfg_do(reg_cfg_do),
      .reg_val_we(reg_val_we), .reg_val_di(reg_val_di), .reg_val_do(reg_val_do),
      .reg_cmp_we(reg_cmp_we), .reg_cmp_di(reg_cmp_di), .reg_cmp_do(reg_cmp_do),
      .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_do(reg_dat_do),
      .reg_cap_do(reg_cap_do),
      .reg_sts_we(reg_sts_we), .reg_sts_di(reg_sts_di), .reg_sts_do(reg_sts_do),
      .cap_in(cap_in), .pwm_out(pwm_out), .stop_out(stop_out), .irq_out(irq_out)
   );

   counter_timer_pwm #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
      .clkin(clkin), .resetn(resetn),
      .reg_cfg_we(s_cfg_we), .reg_cfg_di(s_cfg_di), .reg_cfg_do(s_cfg_do),
      .reg_val_we(s_val_we), .reg_val_di(s_val_di), .reg_val_do(s_val_do),
      .reg_cmp_we(s_cmp_we), .reg_cmp_di(s_cmp_di), .reg_cmp_do(s_cmp_do),
      .reg_dat_we(s_dat_we), .reg_dat_di(s_dat_di), .reg_dat_do(s_dat_do),
      .reg_cap_do(s_cap_do),
      .reg_sts_we(s_sts_we), .reg_sts_di(s_sts_di), .reg_sts_do(s_sts_do),
      .cap_in(s_cap_in), .pwm_out(s_pwm_out), .stop_out(s_stop_out), .irq_out(s_irq_out)
   );

   always #5 clkin = ~clkin;

   task automatic step(input int n);
      repeat (n) @(posedge clkin);
      #1;
   endtask

   task automatic wr_cfg(input logic [31:0] d);
      reg_cfg_we = 4'hF; reg_cfg_di = d; step(1); reg_cfg_we = 4'h0;
   endtask

   task automatic wr_val(input logic [31:0] d);
      reg_val_we = 4'hF; reg_val_di = d; step(1); reg_val_we = 4'h0;
   endtask

   task automatic wr_cmp(input logic [31:0] d);
      reg_cmp_we = 4'hF; reg_cmp_di = d; step(1); reg_cmp_we = 4'h0;
   endtask

   task automatic wr_dat(input logic [31:0] d);
      reg_dat_we = 4'hF; reg_dat_di = d; step(1); reg_dat_we = 4'h0;
   endtask

   task automatic clr_sts(input logic [31:0] m);
      reg_sts_we = 1'b1; reg_sts_di = m; step(1); reg_sts_we = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      step(2);
      total_cnt++;
      if ({reg_cfg_do, reg_val_do, reg_cmp_do, reg_dat_do, reg_cap_do, reg_sts_do} !== 192'd0)
         $display("FAIL reset_regs got %h required 0",
                  {reg_cfg_do, reg_val_do, reg_cmp_do, reg_dat_do, reg_cap_do, reg_sts_do});
      else pass_cnt++;
      total_cnt++;
      if ({pwm_out, stop_out, irq_out} !== 3'b000)
         $display("FAIL reset_outs got %b required 000", {pwm_out, stop_out, irq_out});
      else pass_cnt++;
      resetn = 1'b1;
      step(1);
   endtask

   task automatic test_up_continuous;
      wr_val(32'd3);
      wr_cfg(32'h0000_000D);
      for (int k = 0; k < 5; k++) begin
         step(1);
         total_cnt++;
         if (reg_dat_do !== 32'(k % 4))
            $display("FAIL up_seq[%0d] got %0d required %0d", k, reg_dat_do, k % 4);
         else pass_cnt++;
      end
      total_cnt++;
      if (reg_sts_do !== 32'h3 || irq_out !== 1'b0)
         $display("FAIL up_timeout got sts=%h irq=%b required sts=3 irq=0", reg_sts_do, irq_out);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (irq_out !== 1'b1 || reg_dat_do !== 32'd1)
         $display("FAIL up_irq got irq=%b val=%0d required irq=1 val=1", irq_out, reg_dat_do);
      else pass_cnt++;
      clr_sts(32'h1);
      total_cnt++;
      if (reg_sts_do !== 32'h2 || irq_out !== 1'b1)
         $display("FAIL w1c_sts got sts=%h irq=%b required sts=2 irq=1", reg_sts_do, irq_out);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (irq_out !== 1'b0)
         $display("FAIL w1c_irq got %b required 0", irq_out);
      else pass_cnt++;
      wr_cfg(32'h0);
      clr_sts(32'hF);
   endtask

   task automatic test_down_oneshot;
      wr_val(32'd5);
      wr_cfg(32'h0002_0003);
      step(3);
      total_cnt++;
      if (reg_dat_do !== 32'd5 || stop_out !== 1'b0)
         $display("FAIL dn_load got val=%0d stop=%b required val=5 stop=0", reg_dat_do, stop_out);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (reg_dat_do !== 32'd4)
         $display("FAIL dn_first got %0d required 4", reg_dat_do);
      else pass_cnt++;
      step(3);
      total_cnt++;
      if (reg_dat_do !== 32'd3)
         $display("FAIL dn_prescale got %0d required 3", reg_dat_do);
      else pass_cnt++;
      step(11);
      total_cnt++;
      if (reg_dat_do !== 32'd0 || stop_out !== 1'b0)
         $display("FAIL dn_zero got val=%0d stop=%b required val=0 stop=0", reg_dat_do, stop_out);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (stop_out !== 1'b1 || reg_cfg_do !== 32'h0002_0002 || reg_sts_do[0] !== 1'b1)
         $display("FAIL dn_stop got stop=%b cfg=%h sts=%h required stop=1 cfg=00020002 timeout=1",
                  stop_out, reg_cfg_do, reg_sts_do);
      else pass_cnt++;
      step(4);
      total_cnt++;
      if (reg_dat_do !== 32'd0 || stop_out !== 1'b1)
         $display("FAIL dn_hold got val=%0d stop=%b required val=0 stop=1", reg_dat_do, stop_out);
      else pass_cnt++;
      wr_cfg(32'h0002_0003);
      step(1);
      total_cnt++;
      if (reg_dat_do !== 32'd5 || stop_out !== 1'b0)
         $display("FAIL dn_reen got val=%0d stop=%b required val=5 stop=0", reg_dat_do, stop_out);
      else pass_cnt++;
      wr_cfg(32'h0);
      clr_sts(32'hF);
   endtask

   task automatic test_pwm;
      int highs;
      wr_val(32'd9);
      wr_cmp(32'd4);
      wr_cfg(32'h0000_0025);
      step(2);
      highs = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (pwm_out === 1'b1) highs++;
      end
      total_cnt++;
      if (highs !== 4) $display("FAIL pwm_pol0 got %0d high of 10 required 4", highs);
      else pass_cnt++;
      wr_cfg(32'h0000_0065);
      step(1);
      highs = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (pwm_out === 1'b1) highs++;
      end
      total_cnt++;
      if (highs !== 6) $display("FAIL pwm_pol1 got %0d high of 10 required 6", highs);
      else pass_cnt++;
      wr_cmp(32'd0);
      wr_cfg(32'h0000_0025);
      step(1);
      highs = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (pwm_out === 1'b1) highs++;
      end
      total_cnt++;
      if (highs !== 0) $display("FAIL pwm_cmp0 got %0d high of 10 required 0", highs);
      else pass_cnt++;
      wr_cfg(32'h0);
      clr_sts(32'hF);
   endtask

   task automatic test_capture;
      wr_dat(32'h55);
      wr_cfg(32'h0000_0380);
      cap_in = 1'b1;
      step(2);
      total_cnt++;
      if (reg_cap_do !== 32'h0)
         $display("FAIL cap_latency got %h required 0", reg_cap_do);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (reg_cap_do !== 32'h55 || reg_sts_do !== 32'h4)
         $display("FAIL cap_rise got cap=%h sts=%h required cap=55 sts=4", reg_cap_do, reg_sts_do);
      else pass_cnt++;
      wr_dat(32'h77);
      cap_in = 1'b0;
      step(2);
      total_cnt++;
      if (reg_cap_do !== 32'h55)
         $display("FAIL cap_fall_early got %h required 55", reg_cap_do);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (reg_cap_do !== 32'h77 || reg_sts_do !== 32'hC)
         $display("FAIL cap_ovr got cap=%h sts=%h required cap=77 sts=c", reg_cap_do, reg_sts_do);
      else pass_cnt++;
      wr_cfg(32'h0000_0080);
      clr_sts(32'hF);
      wr_dat(32'h99);
      cap_in = 1'b1;
      step(5);
      total_cnt++;
      if (reg_cap_do !== 32'h77 || reg_sts_do !== 32'h0)
         $display("FAIL cap_none got cap=%h sts=%h required cap=77 sts=0", reg_cap_do, reg_sts_do);
      else pass_cnt++;
      cap_in = 1'b0;
      wr_cfg(32'h0);
      step(4);
   endtask

   task automatic test_dat_load;
      wr_val(32'h1000);
      wr_cfg(32'h0000_0005);
      step(3);
      total_cnt++;
      if (reg_dat_do !== 32'd2)
         $display("FAIL load_pre got %h required 2", reg_dat_do);
      else pass_cnt++;
      wr_dat(32'h100);
      total_cnt++;
      if (reg_dat_do !== 32'h100)
         $display("FAIL load_wins got %h required 100", reg_dat_do);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (reg_dat_do !== 32'h101)
         $display("FAIL load_next got %h required 101", reg_dat_do);
      else pass_cnt++;
      wr_cfg(32'h0);
      clr_sts(32'hF);
   endtask

   task automatic test_wrap16_reset;
      s_val_we = 2'b11; s_val_di = 16'hFFFF; step(1); s_val_we = 2'b00;
      s_cfg_we = 4'hF; s_cfg_di = 32'h0000_0005; step(1); s_cfg_we = 4'h0;
      step(1);
      s_dat_we = 2'b11; s_dat_di = 16'hFFFD; step(1); s_dat_we = 2'b00;
      total_cnt++;
      if (s_dat_do !== 16'hFFFD)
         $display("FAIL w16_load got %h required fffd", s_dat_do);
      else pass_cnt++;
      step(2);
      total_cnt++;
      if (s_dat_do !== 16'hFFFF)
         $display("FAIL w16_max got %h required ffff", s_dat_do);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (s_dat_do !== 16'h0 || s_sts_do !== 32'h3)
         $display("FAIL w16_wrap got val=%h sts=%h required val=0 sts=3", s_dat_do, s_sts_do);
      else pass_cnt++;
      step(2);
      #2 resetn = 1'b0;
      #1;
      total_cnt++;
      if ({s_cfg_do, s_val_do, s_dat_do, s_sts_do, s_cap_do, s_pwm_out, s_stop_out, s_irq_out} !== 115'd0)
         $display("FAIL w16_async_reset got cfg=%h val=%h dat=%h sts=%h required all 0",
                  s_cfg_do, s_val_do, s_dat_do, s_sts_do);
      else pass_cnt++;
      total_cnt++;
      if ({reg_val_do, reg_dat_do, reg_cap_do} !== 96'd0)
         $display("FAIL w32_async_reset got val=%h dat=%h cap=%h required 0",
                  reg_val_do, reg_dat_do, reg_cap_do);
      else pass_cnt++;
      step(2);
      resetn = 1'b1;
      step(1);
   endtask

   initial begin
      reg_cfg_we = 4'h0; reg_cfg_di = 32'h0;
      reg_val_we = 4'h0; reg_val_di = 32'h0;
      reg_cmp_we = 4'h0; reg_cmp_di = 32'h0;
      reg_dat_we = 4'h0; reg_dat_di = 32'h0;
      reg_sts_we = 1'b0; reg_sts_di = 32'h0;
      cap_in     = 1'b0;
      s_cfg_we = 4'h0; s_cfg_di = 32'h0;
      s_val_we = 2'b00; s_val_di = 16'h0;
      s_cmp_we = 2'b00; s_cmp_di = 16'h0;
      s_dat_we = 2'b00; s_dat_di = 16'h0;
      s_sts_we = 1'b0; s_sts_di = 32'h0;
      s_cap_in = 1'b0;
      test_reset();
      test_up_continuous();
      test_down_oneshot();
      test_pwm();
      test_capture();
      test_dat_load();
      test_wrap16_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
